rs_adder_station: RTL

//  Parametrised Tomasulo reservation station for the adder functional unit.

---
 rtl/rs_adder_station.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/rs_adder_station.sv
// Tomasulo reservation station for the adder unit: renames sources, snoops the CDB, issues lowest ready entry.
// Optional RS_BYPASS_EN: forward a same-cycle CDB broadcast into a dispatching instruction instead of stalling.

module rs_entry #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc,
    input  logic [2:0]        alloc_op,
    input  logic [TAG_W-1:0]  alloc_qj,
    input  logic [TAG_W-1:0]  alloc_qk,
    input  logic [DATA_W-1:0] alloc_vj,
    input  logic [DATA_W-1:0] alloc_vk,
    input  logic              clear,
    input  logic              snoop,
    input  logic [TAG_W-1:0]  snoop_tag,
    input  logic [DATA_W-1:0] snoop_data,
    output logic              busy,
    output logic              ready,
    output logic [2:0]        op,
    output logic [DATA_W-1:0] vj,
    output logic [DATA_W-1:0] vk
);
    logic [TAG_W-1:0] qj, qk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            op   <= '0;
            qj   <= '0;
            qk   <= '0;
            vj   <= '0;
            vk   <= '0;
        end else if (alloc) begin
            busy <= 1'b1;
            op   <= alloc_op;
            qj   <= alloc_qj;
            qk   <= alloc_qk;
            vj   <= alloc_vj;
            vk   <= alloc_vk;
        end else begin
            if (clear)
                busy <= 1'b0;
            // snoop_tag is never 0 when snoop is set, so a ready operand is never overwritten
            if (busy && snoop && qj == snoop_tag) begin
                vj <= snoop_data;
                qj <= '0;
            end
            if (busy && snoop && qk == snoop_tag) begin
                vk <= snoop_data;
                qk <= '0;
            end
        end
    end

    assign ready = busy && (qj == '0) && (qk == '0);
endmodule

module rs_adder_station #(
    parameter int N_ENTRIES = 7,
    parameter int DATA_W    = 16,
    parameter int TAG_W     = 3,
    parameter int N_REGS    = 8
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    input  logic [15:0]          disp_instr,
    input  logic [DATA_W-1:0]    disp_vj,
    input  logic [DATA_W-1:0]    disp_vk,
    input  logic                 cdb_valid,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic [DATA_W-1:0]    cdb_data,
    output logic                 iss_valid,
    input  logic                 iss_ready,
    output logic [2:0]           iss_op,
    output logic [DATA_W-1:0]    iss_vj,
    output logic [DATA_W-1:0]    iss_vk,
    output logic [TAG_W-1:0]     iss_tag,
    output logic [N_ENTRIES-1:0] busy
);
    logic [2:0] op, dest, src_j, src_k;
    logic       unused_bits;
    assign {op, dest, src_j, src_k} = disp_instr[15:4];
    assign unused_bits = ^disp_instr[3:0];

    logic snoop;
    assign snoop = cdb_valid && (cdb_tag != '0);

    logic [N_ENTRIES-1:0]             ready, alloc, clear;
    logic [N_ENTRIES-1:0][2:0]        ent_op;
    logic [N_ENTRIES-1:0][DATA_W-1:0] ent_vj, ent_vk;
    logic [TAG_W-1:0]                 status [N_REGS];

    // Lowest-index free entry; busy is registered so an entry freed this edge is not reused until the next
    logic                 any_free;
    logic [TAG_W-1:0]     alloc_tag;
    logic [N_ENTRIES-1:0] free_sel;
    always_comb begin
        any_free  = 1'b0;
        alloc_tag = '0;
        free_sel  = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                any_free    = 1'b1;
                alloc_tag   = TAG_W'(i + 1);
                free_sel    = '0;
                free_sel[i] = 1'b1;
            end
        end
    end

`ifdef RS_BYPASS_EN
    assign disp_ready = any_free;
`else
    assign disp_ready = any_free && !cdb_valid;
`endif

    logic disp_fire;
    assign disp_fire = disp_valid && disp_ready;
    assign alloc     = disp_fire ? free_sel : '0;

    // Sources read the old status, so src == dest picks up the previous producer
    logic [TAG_W-1:0]  qj, qk;
    logic [DATA_W-1:0] vj, vk;
    always_comb begin
        qj = status[src_j];
        qk = status[src_k];
        vj = disp_vj;
        vk = disp_vk;
`ifdef RS_BYPASS_EN
        if (snoop && qj == cdb_tag) begin
            qj = '0;
            vj = cdb_data;
        end
        if (snoop && qk == cdb_tag) begin
            qk = '0;
            vk = cdb_data;
        end
`endif
    end

    logic                 any_ready;
    logic [N_ENTRIES-1:0] sel_vec;
    logic [2:0]           sel_op;
    logic [DATA_W-1:0]    sel_vj, sel_vk;
    logic [TAG_W-1:0]     sel_tag;
    always_comb begin
        any_ready = 1'b0;
        sel_vec   = '0;
        sel_op    = '0;
        sel_vj    = '0;
        sel_vk    = '0;
        sel_tag   = '0;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (ready[i]) begin
                any_ready  = 1'b1;
                sel_vec    = '0;
                sel_vec[i] = 1'b1;
                sel_op     = ent_op[i];
                sel_vj     = ent_vj[i];
                sel_vk     = ent_vk[i];
                sel_tag    = TAG_W'(i + 1);
            end
        end
    end

    logic iss_load, iss_fire;
    assign iss_load = !iss_valid || iss_ready;
    assign iss_fire = iss_load && any_ready;
    assign clear    = iss_fire ? sel_vec : '0;

    for (genvar g = 0; g < N_ENTRIES; g++) begin : g_ent
        rs_entry #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_ent (
            .clk        (Clock),
            .rst_n      (Resetn),
            .alloc      (alloc[g]),
            .alloc_op   (op),
            .alloc_qj   (qj),
            .alloc_qk   (qk),
            .alloc_vj   (vj),
            .alloc_vk   (vk),
            .clear      (clear[g]),
            .snoop      (snoop),
            .snoop_tag  (cdb_tag),
            .snoop_data (cdb_data),
            .busy       (busy[g]),
            .ready      (ready[g]),
            .op         (ent_op[g]),
            .vj         (ent_vj[g]),
            .vk         (ent_vk[g])
        );
    end

    // A dispatch renaming a register wins over a CDB clear of the same register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int r = 0; r < N_REGS; r++)
                status[r] <= '0;
        end else begin
            for (int r = 0; r < N_REGS; r++) begin
                if (disp_fire && dest == 3'(r))
                    status[r] <= alloc_tag;
                else if (snoop && status[r] == cdb_tag)
                    status[r] <= '0;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            iss_valid <= 1'b0;
            iss_op    <= '0;
            iss_vj    <= '0;
            iss_vk    <= '0;
            iss_tag   <= '0;
        end else if (iss_load) begin
            iss_valid <= any_ready;
            if (any_ready) begin
                iss_op  <= sel_op;
                iss_vj  <= sel_vj;
                iss_vk  <= sel_vk;
                iss_tag <= sel_tag;
            end
        end
    end
endmodule
